// File: rtl/bus_arbiter.sv
// Two-master, five-slave bus arbiter with address decode and error response for unmapped accesses.
// Optional macro ARBITER_ROUND_ROBIN_EN switches tie-breaking from fixed dmem priority to alternating.
module bus_arbiter #(
    parameter logic [31:0] rom_base   = 32'h0,
    parameter logic [31:0] rom_top    = 32'h80,
    parameter logic [31:0] uart_base  = 32'h1000000,
    parameter logic [31:0] uart_top   = 32'h1000004,
    parameter logic [31:0] clint_base = 32'h2000000,
    parameter logic [31:0] clint_top  = 32'h200C000,
    parameter logic [31:0] clic_base  = 32'h3000000,
    parameter logic [31:0] clic_top   = 32'h3005000,
    parameter logic [31:0] wb_base    = 32'h80000000,
    parameter logic [31:0] wb_top     = 32'h90000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    output logic        imem_error,
    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        dmem_error,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        rom_valid,
    output logic        uart_valid,
    output logic        clint_valid,
    output logic        clic_valid,
    output logic        wb_valid,
    input  logic        rom_ready,
    input  logic        uart_ready,
    input  logic        clint_ready,
    input  logic        clic_ready,
    input  logic        wb_ready,
    input  logic [31:0] rom_rdata,
    input  logic [31:0] uart_rdata,
    input  logic [31:0] clint_rdata,
    input  logic [31:0] clic_rdata,
    input  logic [31:0] wb_rdata
);

    typedef enum logic [1:0] {StIdle, StBusy, StErr} state_t;

    state_t      state_q;
    logic        grant_dmem_q;
    logic        pick_dmem;
    logic [31:0] req_addr;
    logic [4:0]  hit;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        done_ok;
    logic        done_err;

    function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a < hi);
    endfunction

    // grant_dmem_q doubles as the last-grant record for round-robin tie breaking.
    always_comb begin
`ifdef ARBITER_ROUND_ROBIN_EN
        pick_dmem = dmem_valid & (~imem_valid | ~grant_dmem_q);
`else
        pick_dmem = dmem_valid;
`endif
        req_addr = pick_dmem ? dmem_addr : imem_addr;
        hit[0] = in_range(req_addr, rom_base, rom_top);
        hit[1] = in_range(req_addr, uart_base, uart_top);
        hit[2] = in_range(req_addr, clint_base, clint_top);
        hit[3] = in_range(req_addr, clic_base, clic_top);
        hit[4] = in_range(req_addr, wb_base, wb_top);
    end

    always_comb begin
        sel_ready = (rom_valid & rom_ready) | (uart_valid & uart_ready) |
                    (clint_valid & clint_ready) | (clic_valid & clic_ready) |
                    (wb_valid & wb_ready);
        sel_rdata = ({32{rom_valid}} & rom_rdata) | ({32{uart_valid}} & uart_rdata) |
                    ({32{clint_valid}} & clint_rdata) | ({32{clic_valid}} & clic_rdata) |
                    ({32{wb_valid}} & wb_rdata);
        done_ok  = (state_q == StBusy) && sel_ready;
        done_err = (state_q == StErr);
    end

    always_comb begin
        imem_ready = ~grant_dmem_q & (done_ok | done_err);
        imem_error = ~grant_dmem_q & done_err;
        imem_rdata = (~grant_dmem_q & done_ok) ? sel_rdata : 32'h0;
        dmem_ready = grant_dmem_q & (done_ok | done_err);
        dmem_error = grant_dmem_q & done_err;
        dmem_rdata = (grant_dmem_q & done_ok) ? sel_rdata : 32'h0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_dmem_q <= 1'b0;
            mem_instr    <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            mem_wstrb    <= 4'h0;
            {wb_valid, clic_valid, clint_valid, uart_valid, rom_valid} <= 5'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (imem_valid | dmem_valid) begin
                        grant_dmem_q <= pick_dmem;
                        mem_instr    <= pick_dmem ? dmem_instr : imem_instr;
                        mem_addr     <= req_addr;
                        mem_wdata    <= pick_dmem ? dmem_wdata : imem_wdata;
                        mem_wstrb    <= pick_dmem ? dmem_wstrb : imem_wstrb;
                        if (|hit) begin
                            {wb_valid, clic_valid, clint_valid, uart_valid, rom_valid} <= hit;
                            state_q <= StBusy;
                        end else begin
                            state_q <= StErr;
                        end
                    end
                end
                StBusy: begin
                    if (sel_ready) begin
                        {wb_valid, clic_valid, clint_valid, uart_valid, rom_valid} <= 5'b0;
                        state_q <= StIdle;
                    end
                end
                StErr:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; tie-break expectations follow ARBITER_ROUND_ROBIN_EN.
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_valid, imem_instr, dmem_valid, dmem_instr;
    logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
    logic [3:0]  imem_wstrb, dmem_wstrb;
    logic [31:0] imem_rdata, dmem_rdata;
    logic        imem_ready, imem_error, dmem_ready, dmem_error;
    logic        mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        rom_valid, uart_valid, clint_valid, clic_valid, wb_valid;
    logic        rom_ready, uart_ready, clint_ready, clic_ready, wb_ready;
    logic [31:0] rom_rdata, uart_rdata, clint_rdata, clic_rdata, wb_rdata;
    logic [4:0]  sv;

    int checks = 0;
    int failures = 0;

    assign sv = {wb_valid, clic_valid, clint_valid, uart_valid, rom_valid};

    always #5 clock = ~clock;

    bus_arbiter dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .imem_error(imem_error),
        .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .dmem_error(dmem_error),
        .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .rom_valid(rom_valid), .uart_valid(uart_valid), .clint_valid(clint_valid),
        .clic_valid(clic_valid), .wb_valid(wb_valid),
        .rom_ready(rom_ready), .uart_ready(uart_ready), .clint_ready(clint_ready),
        .clic_ready(clic_ready), .wb_ready(wb_ready),
        .rom_rdata(rom_rdata), .uart_rdata(uart_rdata), .clint_rdata(clint_rdata),
        .clic_rdata(clic_rdata), .wb_rdata(wb_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0] bnd_addr [3];
    logic [4:0]  bnd_sv   [3];
    logic        tie_dmem [3];

    initial begin
        bnd_addr[0] = 32'h2000000;  bnd_sv[0] = 5'b00100;
        bnd_addr[1] = 32'h200BFFF;  bnd_sv[1] = 5'b00100;
        bnd_addr[2] = 32'h200C000;  bnd_sv[2] = 5'b00000;
`ifdef ARBITER_ROUND_ROBIN_EN
        tie_dmem[0] = 1'b1; tie_dmem[1] = 1'b0; tie_dmem[2] = 1'b1;
`else
        tie_dmem[0] = 1'b1; tie_dmem[1] = 1'b1; tie_dmem[2] = 1'b1;
`endif
        reset = 1'b1;
        imem_valid = 0; imem_instr = 0; imem_addr = 0; imem_wdata = 0; imem_wstrb = 0;
        dmem_valid = 0; dmem_instr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
        rom_ready = 0; uart_ready = 0; clint_ready = 0; clic_ready = 0; wb_ready = 0;
        rom_rdata = 0; uart_rdata = 0; clint_rdata = 0; clic_rdata = 0; wb_rdata = 0;
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_sv", {27'h0, sv}, 32'h0);
        check_eq("rst_ready", {30'h0, imem_ready, dmem_ready}, 32'h0);
        check_eq("rst_error", {30'h0, imem_error, dmem_error}, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_fields", {mem_wdata[27:0], mem_wstrb}, 32'h0);
        check_eq("rst_rdata", imem_rdata | dmem_rdata, 32'h0);
        reset = 1'b0;

        // Zero-wait ROM read
        imem_valid = 1; imem_addr = 32'h40; imem_wstrb = 0; imem_instr = 1;
        rom_ready = 1; rom_rdata = 32'h13;
        @(negedge clock);
        check_eq("rom_sv", {27'h0, sv}, 32'h1);
        check_eq("rom_ready", {31'h0, imem_ready}, 32'h1);
        check_eq("rom_rdata", imem_rdata, 32'h13);
        check_eq("rom_error", {31'h0, imem_error}, 32'h0);
        check_eq("rom_dmem_ready", {31'h0, dmem_ready}, 32'h0);
        check_eq("rom_mem_addr", mem_addr, 32'h40);
        check_eq("rom_mem_instr", {31'h0, mem_instr}, 32'h1);
        imem_valid = 0;
        @(negedge clock);
        check_eq("rom_idle_sv", {27'h0, sv}, 32'h0);
        check_eq("rom_idle_ready", {31'h0, imem_ready}, 32'h0);
        check_eq("rom_idle_rdata", imem_rdata, 32'h0);
        rom_ready = 0;

        // Wishbone write with three wait cycles
        dmem_valid = 1; dmem_addr = 32'h80000010; dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'hF;
        wb_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 3) begin
                wb_ready = 1;
                #1;
            end
            check_eq($sformatf("wb_sv%0d", i), {27'h0, sv}, 32'h10);
            check_eq($sformatf("wb_addr%0d", i), mem_addr, 32'h80000010);
            check_eq($sformatf("wb_wdata%0d", i), mem_wdata, 32'hDEADBEEF);
            check_eq($sformatf("wb_wstrb%0d", i), {28'h0, mem_wstrb}, 32'hF);
            check_eq($sformatf("wb_ready%0d", i), {31'h0, dmem_ready}, (i == 3) ? 32'h1 : 32'h0);
            if (i == 1) dmem_wdata = 32'h12345678;
        end
        check_eq("wb_rdata", dmem_rdata, 32'hCAFEF00D);
        check_eq("wb_imem_ready", {31'h0, imem_ready}, 32'h0);
        dmem_valid = 0;
        @(negedge clock);
        check_eq("wb_idle_sv", {27'h0, sv}, 32'h0);
        check_eq("wb_idle_ready", {31'h0, dmem_ready}, 32'h0);
        wb_ready = 0;

        // Unmapped access at rom_top
        dmem_valid = 1; dmem_addr = 32'h80; dmem_wstrb = 0;
        rom_ready = 1;
        @(negedge clock);
        check_eq("err_sv", {27'h0, sv}, 32'h0);
        check_eq("err_ready", {31'h0, dmem_ready}, 32'h1);
        check_eq("err_error", {31'h0, dmem_error}, 32'h1);
        check_eq("err_rdata", dmem_rdata, 32'h0);
        dmem_valid = 0;
        @(negedge clock);
        check_eq("err_idle", {30'h0, dmem_ready, dmem_error}, 32'h0);
        rom_ready = 0;

        // CLINT boundary decode
        clint_ready = 1; clint_rdata = 32'h55;
        for (int i = 0; i < 3; i++) begin
            imem_valid = 1; imem_addr = bnd_addr[i];
            @(negedge clock);
            check_eq($sformatf("bnd_sv%0d", i), {27'h0, sv}, {27'h0, bnd_sv[i]});
            check_eq($sformatf("bnd_ready%0d", i), {31'h0, imem_ready}, 32'h1);
            check_eq($sformatf("bnd_error%0d", i), {31'h0, imem_error},
                     (bnd_sv[i] == 5'b0) ? 32'h1 : 32'h0);
            imem_valid = 0;
            @(negedge clock);
        end

        // Back-to-back ties: dmem to UART, imem to CLINT
        uart_ready = 1; uart_rdata = 32'h11; clint_rdata = 32'h22;
        dmem_valid = 1; dmem_addr = 32'h1000000;
        imem_valid = 1; imem_addr = 32'h200BFF8;
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            check_eq($sformatf("tie_dready%0d", t), {31'h0, dmem_ready}, {31'h0, tie_dmem[t]});
            check_eq($sformatf("tie_iready%0d", t), {31'h0, imem_ready}, {31'h0, ~tie_dmem[t]});
            check_eq($sformatf("tie_sv%0d", t), {27'h0, sv}, tie_dmem[t] ? 32'h2 : 32'h4);
            check_eq($sformatf("tie_rdata%0d", t), dmem_rdata | imem_rdata,
                     tie_dmem[t] ? 32'h11 : 32'h22);
            @(negedge clock);
            check_eq($sformatf("tie_gap%0d", t), {30'h0, dmem_ready, imem_ready}, 32'h0);
        end
        dmem_valid = 0; imem_valid = 0;
        uart_ready = 0; clint_ready = 0;
        @(negedge clock);

        // Reset while CLIC transaction is pending
        imem_valid = 1; imem_addr = 32'h3000010; imem_wdata = 32'hA5A5A5A5; imem_wstrb = 4'h3;
        clic_rdata = 32'h77;
        @(negedge clock);
        check_eq("clic_sv", {27'h0, sv}, 32'h8);
        check_eq("clic_wait", {31'h0, imem_ready}, 32'h0);
        reset = 1; imem_valid = 0;
        @(negedge clock);
        check_eq("rstb_sv", {27'h0, sv}, 32'h0);
        check_eq("rstb_mem_addr", mem_addr, 32'h0);
        check_eq("rstb_mem_wdata", mem_wdata, 32'h0);
        check_eq("rstb_ready", {30'h0, imem_ready, dmem_ready}, 32'h0);
        reset = 0; clic_ready = 1;
        @(negedge clock);
        check_eq("late_ready", {30'h0, imem_ready, dmem_ready}, 32'h0);
        check_eq("late_sv", {27'h0, sv}, 32'h0);
        check_eq("late_rdata", imem_rdata, 32'h0);
        clic_ready = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
